// File: rtl/escritor_pixeles_pkg.sv
// ------------------------------------------------------------------
// escritor_pixeles_pkg : shared state encoding and mask constants (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

package escritor_pixeles_pkg;

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    ESCRIBIENDO = 2'd1,
    VACIANDO    = 2'd2
  } estado_t;

  localparam int MASCARA_3 = 3;
  localparam int MASCARA_5 = 5;

  function automatic logic mascara_legal(input int m);
    return (m == MASCARA_3) || (m == MASCARA_5);
  endfunction

endpackage

`default_nettype wire

// File: rtl/FlipFlopD_Habilitado.sv
// ------------------------------------------------------------------
// FlipFlopD_Habilitado : D register with load enable (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module FlipFlopD_Habilitado #(
  parameter int BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            habilitar,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] q_q;
  logic [BITS-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (habilitar) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/escritor_pixeles_registro_salida.sv
// ------------------------------------------------------------------
// registro_salida : single-entry valid/ready output register (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module registro_salida #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cargar,
  input  logic [BITS-1:0] dato_entrada,
  input  logic            listo_salida,
  output logic            libre,
  output logic            valido_salida,
  output logic [BITS-1:0] dato_salida
);

  logic            valido_q, valido_d;
  logic [BITS-1:0] dato_q, dato_d;

  // A load may coincide with the outgoing transfer, giving 1 pixel/cycle.
  always_comb begin
    valido_d = valido_q;
    dato_d   = dato_q;
    if (cargar) begin
      valido_d = 1'b1;
      dato_d   = dato_entrada;
    end else if (listo_salida) begin
      valido_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valido_q <= 1'b0;
      dato_q   <= '0;
    end else begin
      valido_q <= valido_d;
      dato_q   <= dato_d;
    end
  end

  assign libre         = !valido_q || listo_salida;
  assign valido_salida = valido_q;
  assign dato_salida   = dato_q;

endmodule

`default_nettype wire

// File: rtl/escritor_pixeles.sv
// ------------------------------------------------------------------
// escritor_pixeles : raster-order image writer with border fill (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module escritor_pixeles
  import escritor_pixeles_pkg::*;
#(
  parameter int BITS_PIXEL   = 8,
  parameter int BITS_BUFFERS = 3,
  parameter int BITS_MASCARA = 3,
  parameter int BITS_COORD   = 11,
  parameter int ANCHO_BASE   = 256,
  parameter int BORDE        = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic [BITS_BUFFERS-1:0] cantidad_buffers_internos,
  input  logic [BITS_MASCARA-1:0] tamano_mascara,
  input  logic [BITS_PIXEL-1:0]   pixel_resultado,
  input  logic                    resultado_valido,
  output logic                    aceptar_resultado,
  output logic [BITS_PIXEL-1:0]   pixel_salida,
  output logic                    write_pixel,
  input  logic                    write_ready,
  output logic [BITS_COORD-1:0]   fila_actual,
  output logic [BITS_COORD-1:0]   columna_actual,
  output logic                    ocupado,
  output logic                    imagen_terminada,
  output logic                    error_config
);

  estado_t                 estado_q, estado_d;
  logic [BITS_BUFFERS-1:0] buffers_q, buffers_d;
  logic [BITS_MASCARA-1:0] mascara_q, mascara_d;
  logic                    error_q, error_d;
  logic                    fin_q, fin_d;

  logic [BITS_COORD-1:0]   fila_q, fila_d;
  logic [BITS_COORD-1:0]   columna_q, columna_d;
  logic                    coord_en;

  logic [BITS_COORD-1:0]   dimension;
  logic [BITS_COORD-1:0]   margen;
  logic                    en_borde;
  logic                    ultima_pos;
  logic                    slot_libre;
  logic                    cargar;
  logic [BITS_PIXEL-1:0]   dato_carga;

  // Image is square; the mask half-width sets the uncovered margin.
  assign dimension  = BITS_COORD'(buffers_q) * BITS_COORD'(ANCHO_BASE);
  assign margen     = BITS_COORD'(mascara_q >> 1);
  assign en_borde   = (fila_q < margen) || (fila_q >= dimension - margen) ||
                      (columna_q < margen) || (columna_q >= dimension - margen);
  assign ultima_pos = (fila_q == dimension - 1'b1) && (columna_q == dimension - 1'b1);

  always_comb begin
    estado_d          = estado_q;
    buffers_d         = buffers_q;
    mascara_d         = mascara_q;
    error_d           = error_q;
    fin_d             = 1'b0;
    fila_d            = fila_q;
    columna_d         = columna_q;
    coord_en          = 1'b0;
    cargar            = 1'b0;
    dato_carga        = BITS_PIXEL'(BORDE);
    aceptar_resultado = 1'b0;

    case (estado_q)
      REPOSO: begin
        if (iniciar) begin
          buffers_d = cantidad_buffers_internos;
          mascara_d = tamano_mascara;
          if ((cantidad_buffers_internos == '0) || !mascara_legal(int'(tamano_mascara))) begin
            error_d = 1'b1;
          end else begin
            error_d   = 1'b0;
            fila_d    = '0;
            columna_d = '0;
            coord_en  = 1'b1;
            estado_d  = ESCRIBIENDO;
          end
        end
      end

      ESCRIBIENDO: begin
        if (en_borde) begin
          cargar = slot_libre;
        end else begin
          aceptar_resultado = slot_libre;
          cargar            = slot_libre && resultado_valido;
          dato_carga        = pixel_resultado;
        end
        // Counters stay on the last position once it is loaded.
        if (cargar) begin
          if (ultima_pos) begin
            estado_d = VACIANDO;
          end else begin
            coord_en = 1'b1;
            if (columna_q == dimension - 1'b1) begin
              columna_d = '0;
              fila_d    = fila_q + 1'b1;
            end else begin
              columna_d = columna_q + 1'b1;
            end
          end
        end
      end

      VACIANDO: begin
        if (write_pixel && write_ready) begin
          fin_d    = 1'b1;
          estado_d = REPOSO;
        end
      end

      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      buffers_q <= '0;
      mascara_q <= '0;
      error_q   <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      buffers_q <= buffers_d;
      mascara_q <= mascara_d;
      error_q   <= error_d;
      fin_q     <= fin_d;
    end
  end

  FlipFlopD_Habilitado #(.BITS(BITS_COORD)) u_fila (
    .clk       (clk),
    .reset     (reset),
    .habilitar (coord_en),
    .d         (fila_d),
    .q         (fila_q)
  );

  FlipFlopD_Habilitado #(.BITS(BITS_COORD)) u_columna (
    .clk       (clk),
    .reset     (reset),
    .habilitar (coord_en),
    .d         (columna_d),
    .q         (columna_q)
  );

  registro_salida #(.BITS(BITS_PIXEL)) u_registro_salida (
    .clk           (clk),
    .reset         (reset),
    .cargar        (cargar),
    .dato_entrada  (dato_carga),
    .listo_salida  (write_ready),
    .libre         (slot_libre),
    .valido_salida (write_pixel),
    .dato_salida   (pixel_salida)
  );

  assign fila_actual      = fila_q;
  assign columna_actual   = columna_q;
  assign ocupado          = (estado_q != REPOSO);
  assign imagen_terminada = fin_q;
  assign error_config     = error_q;

endmodule

`default_nettype wire
